// File: rtl/security_lock_pkg.sv
// Shared constants for the security lock: pushbutton index map, default board timing,
// and the per-channel status bundle produced by the key conditioner.
package security_lock_pkg;

  localparam int KEY_CONFIRM_GETTER = 0;
  localparam int KEY_CONFIRM_FSM    = 1;
  localparam int KEY_SWITCH         = 2;
  localparam int KEY_HARD_RESET     = 3;

  // 20 ms and 2 s expressed in CLOCK_50 cycles.
  localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
  localparam int HOLD_2S_50MHZ       = 100_000_000;

  typedef struct packed {
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic long_level;
    logic long_pulse;
  } key_status_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, restartable debounce counter,
// registered press/release pulses and a saturating long-press detector.
module key_debounce_ch
  import security_lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int HOLD_CYCLES     = HOLD_2S_50MHZ
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_n,
  output key_status_t o_status
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_next;
  logic          level;
  logic          level_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_next;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;

  // Reset value 1 makes a key held through reset look released at reset exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_key_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // Any sample agreeing with the current level is a bounce and restarts the count.
  always_comb begin
    deb_cnt_next = '0;
    level_next   = level;
    if (pressed != level) begin
      if (deb_cnt == DEB_LAST) begin
        level_next = pressed;
      end else begin
        deb_cnt_next = deb_cnt + 1'b1;
      end
    end
  end

  // Cleared on the accepting edge of a release so long_level drops with level.
  always_comb begin
    hold_cnt_next = hold_cnt;
    if (!level_next) begin
      hold_cnt_next = '0;
    end else if (level && (hold_cnt != HOLD_MAX)) begin
      hold_cnt_next = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt       <= '0;
      level         <= 1'b0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      deb_cnt       <= deb_cnt_next;
      level         <= level_next;
      hold_cnt      <= hold_cnt_next;
      press_pulse   <= level_next & ~level;
      release_pulse <= level & ~level_next;
      long_pulse    <= (hold_cnt_next == HOLD_MAX) && (hold_cnt != HOLD_MAX);
    end
  end

  assign o_status.level         = level;
  assign o_status.press_pulse   = press_pulse;
  assign o_status.release_pulse = release_pulse;
  assign o_status.long_level    = (hold_cnt == HOLD_MAX);
  assign o_status.long_pulse    = long_pulse;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low DE2 pushbuttons into clean levels and one-cycle
// events for security_lock_top; every key is an independent channel.
module key_conditioner
  import security_lock_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int HOLD_CYCLES     = HOLD_2S_50MHZ
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse,
  output logic [NUM_KEYS-1:0] o_long_level,
  output logic [NUM_KEYS-1:0] o_long_pulse
);

  key_status_t status [NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_n  (i_key_n[i]),
      .o_status (status[i])
    );

    assign o_level[i]         = status[i].level;
    assign o_press_pulse[i]   = status[i].press_pulse;
    assign o_release_pulse[i] = status[i].release_pulse;
    assign o_long_level[i]    = status[i].long_level;
    assign o_long_pulse[i]    = status[i].long_pulse;
  end

endmodule
